// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding unit for the pipelined MIPS core: tracks in-flight destination tags,
// forwards ready results to decode, raises load-use stalls and redirect flushes.
module hazard_scoreboard #(
    parameter int DATA_W           = 32,
    parameter int REG_ADDR_W       = 5,
    parameter int NUM_STAGES       = 3,
    parameter int ALU_READY_STAGE  = 1,
    parameter int LOAD_READY_STAGE = 2,
    parameter int CNT_W            = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         d_valid,
    input  logic [REG_ADDR_W-1:0]        d_ra0,
    input  logic [REG_ADDR_W-1:0]        d_ra1,
    input  logic [REG_ADDR_W-1:0]        d_wa,
    input  logic                         d_we,
    input  logic                         d_is_load,
    input  logic                         redirect,
    input  logic [DATA_W-1:0]            rf_rd0,
    input  logic [DATA_W-1:0]            rf_rd1,
    input  logic [DATA_W*NUM_STAGES-1:0] stage_data,
    output logic [DATA_W-1:0]            fwd_rd0,
    output logic [DATA_W-1:0]            fwd_rd1,
    output logic                         stall,
    output logic                         flush_fd,
    output logic [CNT_W-1:0]             stall_count,
    output logic [CNT_W-1:0]             flush_count
);

    logic [NUM_STAGES-1:0]                 valid_q, valid_d;
    logic [NUM_STAGES-1:0]                 we_q, we_d;
    logic [NUM_STAGES-1:0]                 ld_q, ld_d;
    logic [NUM_STAGES-1:0][REG_ADDR_W-1:0] wa_q, wa_d;
    logic [CNT_W-1:0]                      stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]                      flush_cnt_q, flush_cnt_d;
    logic                                  haz0, haz1;

    // Returns {hazard, operand}. Scanning oldest to youngest lets the youngest match win.
    function automatic logic [DATA_W:0] lookup(input logic [REG_ADDR_W-1:0] r,
                                               input logic [DATA_W-1:0]     rf);
        logic [DATA_W:0] res;
        res = {1'b0, rf};
        for (int k = NUM_STAGES; k >= 1; k--) begin
            if (valid_q[k-1] && we_q[k-1] && wa_q[k-1] == r && r != '0) begin
                if (k >= (ld_q[k-1] ? LOAD_READY_STAGE : ALU_READY_STAGE))
                    res = {1'b0, stage_data[(k-1)*DATA_W +: DATA_W]};
                else
                    res = {1'b1, rf};
            end
        end
        return res;
    endfunction

    always_comb begin
        {haz0, fwd_rd0} = lookup(d_ra0, rf_rd0);
        {haz1, fwd_rd1} = lookup(d_ra1, rf_rd1);
        stall           = d_valid & (haz0 | haz1);
        // A stalled branch still has unresolved operands, so its redirect waits.
        flush_fd        = redirect & d_valid & ~stall;
    end

    always_comb begin
        // NOTE: every signal gets a default before any condition so no path infers a latch.
        valid_d     = '0;
        we_d        = '0;
        ld_d        = '0;
        wa_d        = '0;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!stall) begin
            valid_d[0] = d_valid;
            we_d[0]    = d_we;
            ld_d[0]    = d_is_load;
            wa_d[0]    = d_wa;
        end
        for (int k = 1; k < NUM_STAGES; k++) begin
            valid_d[k] = valid_q[k-1];
            we_d[k]    = we_q[k-1];
            ld_d[k]    = ld_q[k-1];
            wa_d[k]    = wa_q[k-1];
        end
        if (stall && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + 1'b1;
        if (flush_fd && flush_cnt_q != '1)
            flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            // NOTE: the tag store is a handful of flops, not RAM; it is reset so no stale tag forwards.
            valid_q     <= '0;
            we_q        <= '0;
            ld_q        <= '0;
            wa_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            we_q        <= we_d;
            ld_q        <= ld_d;
            wa_q        <= wa_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: a driver pushes predicted outputs from an
// in-flight instruction list, a negedge monitor pops and compares.
module tb_hazard_scoreboard;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_STAGES = 3;
    localparam int ALU_RDY    = 1;
    localparam int LOAD_RDY   = 2;
    localparam int CNT_W      = 4;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic                         clock = 1'b0;
    logic                         reset;
    logic                         d_valid, d_we, d_is_load, redirect;
    logic [REG_ADDR_W-1:0]        d_ra0, d_ra1, d_wa;
    logic [DATA_W-1:0]            rf_rd0, rf_rd1;
    logic [DATA_W*NUM_STAGES-1:0] stage_data;
    logic [DATA_W-1:0]            fwd_rd0, fwd_rd1;
    logic                         stall, flush_fd;
    logic [CNT_W-1:0]             stall_count, flush_count;

    hazard_scoreboard #(
        .DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .NUM_STAGES(NUM_STAGES),
        .ALU_READY_STAGE(ALU_RDY), .LOAD_READY_STAGE(LOAD_RDY), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset), .d_valid(d_valid), .d_ra0(d_ra0), .d_ra1(d_ra1),
        .d_wa(d_wa), .d_we(d_we), .d_is_load(d_is_load), .redirect(redirect),
        .rf_rd0(rf_rd0), .rf_rd1(rf_rd1), .stage_data(stage_data),
        .fwd_rd0(fwd_rd0), .fwd_rd1(fwd_rd1), .stall(stall), .flush_fd(flush_fd),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [DATA_W-1:0] fwd0, fwd1;
        logic              stall, flush;
        int                sc, fc, cyc;
    } exp_t;

    typedef struct {
        bit                  v;
        bit [REG_ADDR_W-1:0] wa;
        bit                  we;
        bit                  ld;
    } inst_t;

    exp_t  exp_q[$];
    inst_t pipe[$];          // index 0 is the youngest in-flight instruction (stage 1)
    bit    model_known = 1'b0;
    int    sc_m = 0, fc_m = 0, cyc = 0;
    int    checks = 0, errors = 0;
    exp_t  mon_e;

    task automatic check(input string name, input int c, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
        end
    endtask

    // Youngest matching writer decides; it forwards only once it has reached its ready stage.
    function automatic logic [DATA_W:0] resolve(input logic [REG_ADDR_W-1:0] r,
                                                input logic [DATA_W-1:0]     rf);
        if (r == 0) return {1'b0, rf};
        for (int i = 0; i < pipe.size(); i++) begin
            if (pipe[i].v && pipe[i].we && pipe[i].wa == r) begin
                if (i + 1 >= (pipe[i].ld ? LOAD_RDY : ALU_RDY))
                    return {1'b0, stage_data[i*DATA_W +: DATA_W]};
                return {1'b1, rf};
            end
        end
        return {1'b0, rf};
    endfunction

    function automatic exp_t predict();
        exp_t e;
        logic h0, h1;
        {h0, e.fwd0} = resolve(d_ra0, rf_rd0);
        {h1, e.fwd1} = resolve(d_ra1, rf_rd1);
        e.stall = d_valid && (h0 || h1);
        e.flush = redirect && d_valid && !e.stall;
        e.sc    = sc_m;
        e.fc    = fc_m;
        e.cyc   = cyc;
        return e;
    endfunction

    task automatic apply(input bit v, input bit [REG_ADDR_W-1:0] ra0, input bit [REG_ADDR_W-1:0] ra1,
                         input bit [REG_ADDR_W-1:0] wa, input bit we, input bit ld,
                         input bit redir, input bit rst);
        exp_t  e;
        inst_t ent;
        d_valid = v; d_ra0 = ra0; d_ra1 = ra1; d_wa = wa; d_we = we; d_is_load = ld;
        redirect = redir; reset = rst;
        rf_rd0 = $urandom; rf_rd1 = $urandom;
        for (int k = 0; k < NUM_STAGES; k++) stage_data[k*DATA_W +: DATA_W] = $urandom;
        #1;
        e = predict();
        if (model_known) exp_q.push_back(e);
        @(posedge clock);
        #1;
        if (rst) begin
            pipe.delete();
            ent = '{v: 1'b0, wa: '0, we: 1'b0, ld: 1'b0};
            repeat (NUM_STAGES) pipe.push_back(ent);
            sc_m = 0;
            fc_m = 0;
            model_known = 1'b1;
        end else begin
            if (e.stall) ent = '{v: 1'b0, wa: '0, we: 1'b0, ld: 1'b0};
            else         ent = '{v: v, wa: wa, we: we, ld: ld};
            pipe.push_front(ent);
            void'(pipe.pop_back());
            if (e.stall && sc_m < CNT_MAX) sc_m++;
            if (e.flush && fc_m < CNT_MAX) fc_m++;
        end
        cyc++;
    endtask

    initial begin
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("fwd_rd0", mon_e.cyc, 64'(fwd_rd0), 64'(mon_e.fwd0));
                check("fwd_rd1", mon_e.cyc, 64'(fwd_rd1), 64'(mon_e.fwd1));
                check("stall", mon_e.cyc, 64'(stall), 64'(mon_e.stall));
                check("flush_fd", mon_e.cyc, 64'(flush_fd), 64'(mon_e.flush));
                check("stall_count", mon_e.cyc, 64'(stall_count), 64'(mon_e.sc));
                check("flush_count", mon_e.cyc, 64'(flush_count), 64'(mon_e.fc));
            end
        end
    end

    initial begin
        reset = 1'b1; d_valid = 1'b0; d_ra0 = '0; d_ra1 = '0; d_wa = '0;
        d_we = 1'b0; d_is_load = 1'b0; redirect = 1'b0;
        rf_rd0 = '0; rf_rd1 = '0; stage_data = '0;
        @(posedge clock);
        #1;
        apply(0, 0, 0, 0, 0, 0, 0, 1);
        // empty scoreboard: register file passes through
        apply(1, 3, 0, 0, 0, 0, 0, 0);
        // ALU producer forwarded from stage 1, then stage 2
        apply(1, 0, 0, 5, 1, 0, 0, 0);
        apply(1, 0, 5, 0, 0, 0, 0, 0);
        apply(1, 0, 5, 0, 0, 0, 0, 0);
        // load-use: one stall, then forward from stage 2
        apply(1, 0, 0, 7, 1, 1, 0, 0);
        apply(1, 7, 0, 0, 0, 0, 0, 0);
        apply(1, 7, 0, 0, 0, 0, 0, 0);
        // two writers of r9 at stages 1 and 3: youngest wins
        apply(1, 0, 0, 9, 1, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0, 0, 0);
        apply(1, 0, 0, 9, 1, 0, 0, 0);
        apply(1, 9, 9, 0, 0, 0, 0, 0);
        // writer to r0 never forwards
        apply(1, 0, 0, 0, 1, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0, 0, 0);
        // redirect without hazard, redirect held across a load-use stall, redirect with no instruction
        apply(1, 0, 0, 0, 0, 0, 1, 0);
        apply(1, 0, 0, 7, 1, 1, 0, 0);
        apply(1, 7, 0, 0, 0, 0, 1, 0);
        apply(1, 7, 0, 0, 0, 0, 1, 0);
        apply(0, 0, 0, 0, 0, 0, 1, 0);
        // chained lw r7 <- r7: a stall every other cycle, driving the counter into saturation
        repeat (44) apply(1, 7, 0, 7, 1, 1, 0, 0);
        // reset asserted mid-stall drops the in-flight load
        apply(1, 0, 0, 7, 1, 1, 0, 0);
        apply(1, 7, 0, 7, 1, 1, 0, 1);
        apply(1, 7, 0, 0, 0, 0, 0, 0);
        // randomized traffic over a small register window to force frequent collisions
        for (int i = 0; i < 3000; i++) begin
            apply($urandom_range(99, 0) < 85,
                  5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)),
                  $urandom_range(99, 0) < 75, $urandom_range(99, 0) < 35,
                  $urandom_range(99, 0) < 20, $urandom_range(99, 0) < 2);
        end
        repeat (2) @(negedge clock);
        check("expect_queue_drained", cyc, 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
